log_kulisch_accumulator: RTL and testbench

Sequential accumulator that consumes a valid/ready stream of unpacked log-domain numbers and sums their linear values into a Kulisch fixed-point register. Each input is converted through the combinational log-to-linear-fixed add path (accOut = accIn + linear(logIn)), and the result is written back into the accumulator. On the beat flagged `in_last`, the completed sum is snapshotted into an output register. The accumulator then clears for the next vector. The block sits directly downstream of the log multiplier array and upstream of the fixed-to-float/log re-encoder.

---
 rtl/log_kulisch_accumulator_pkg.sv | 21 ++
 rtl/log_kulisch_accumulator_flag_merge.sv | 26 ++
 rtl/log_kulisch_accumulator_log_add.sv | 49 ++++
 rtl/log_kulisch_accumulator.sv | 122 ++++++++++++
 tb/tb_log_kulisch_accumulator.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/log_kulisch_accumulator_pkg.sv
// Shared types for the log-domain Kulisch accumulator: sticky flag bundle,
// control states and the accumulator width helper.
package log_kulisch_accumulator_pkg;

   typedef struct packed {
      logic inf;
      logic inf_sign;
      logic nan;
      logic overflow;
   } kulisch_flags_t;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } acc_state_t;

   function automatic int acc_width(input int non_frac, input int frac);
      return non_frac + frac;
   endfunction

endpackage

// File: rtl/log_kulisch_accumulator_flag_merge.sv
// Merges one beat's special-value status into the sticky inf/nan/overflow flags.
module kulisch_flag_merge
   import log_kulisch_accumulator_pkg::*;
#(
   parameter int OVERFLOW_DETECTION = 0
) (
   input  kulisch_flags_t cur,
   input  logic           beat_inf,
   input  logic           beat_sign,
   input  logic           beat_ovf,
   output kulisch_flags_t merged
);

   logic nan_next;

   always_comb begin
      nan_next = cur.nan | (beat_inf & cur.inf & (cur.inf_sign != beat_sign));
      merged = '0;
      merged.nan = nan_next;
      // Once nan is set, inf stays cleared for the rest of the vector.
      merged.inf = ~nan_next & (cur.inf | beat_inf);
      merged.inf_sign = nan_next ? 1'b0 : (cur.inf ? cur.inf_sign : (beat_inf & beat_sign));
      merged.overflow = (OVERFLOW_DETECTION != 0) & (cur.overflow | beat_ovf);
   end

endmodule

// File: rtl/log_kulisch_accumulator_log_add.sv
// Combinational log -> linear fixed-point conversion and add: acc_out = acc_in + linear(log_in).
module kulisch_log_add #(
   parameter int M                  = 5,
   parameter int F                  = 10,
   parameter int LOG_TO_LINEAR_BITS = 8,
   parameter int ACC_FRAC           = 16,
   parameter int W                  = 32
) (
   input  logic [W-1:0]   acc_in,
   input  logic           sign,
   input  logic           zero,
   input  logic           inf,
   input  logic [M+F-1:0] log_in,
   output logic [W-1:0]   acc_out,
   output logic           ovf
);

   localparam int L = LOG_TO_LINEAR_BITS;

   int           exp_int;
   int           shift;
   logic [F:0]   mant;
   logic [2*W-1:0] mant_wide;
   logic [2*W-1:0] mag_wide;
   logic         mag_ovf;
   logic [W-1:0] term;

   always_comb begin
      exp_int = int'($signed(log_in[M+F-1:F]));
      // 2^frac approximated as 1.frac, truncated to L fractional bits.
      mant = {1'b1, log_in[F-1:0]} >> (F - L);
      mant_wide = {{(2*W-F-1){1'b0}}, mant};
      shift = exp_int + ACC_FRAC - L;
      if (shift >= 0) begin
         mag_wide = mant_wide << shift;
      end else begin
         mag_wide = mant_wide >> (-shift);
      end
      mag_ovf = |mag_wide[2*W-1:W-1];
      term = sign ? -mag_wide[W-1:0] : mag_wide[W-1:0];
      if (zero || inf) begin
         term = '0;
         mag_ovf = 1'b0;
      end
      acc_out = acc_in + term;
      ovf = mag_ovf | ((acc_in[W-1] == term[W-1]) & (acc_out[W-1] != acc_in[W-1]));
   end

endmodule

// File: rtl/log_kulisch_accumulator.sv
// Streams log-domain values into a Kulisch fixed-point accumulator and hands
// out one completed sum per vector through a holding output register.
module log_kulisch_accumulator
   import log_kulisch_accumulator_pkg::*;
#(
   parameter int M                  = 5,
   parameter int F                  = 10,
   parameter int LOG_TO_LINEAR_BITS = 8,
   parameter int ACC_NON_FRAC       = 16,
   parameter int ACC_FRAC           = 16,
   parameter int OVERFLOW_DETECTION = 0
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             in_sign,
   input  logic                             in_zero,
   input  logic                             in_inf,
   input  logic [M+F-1:0]                   in_log,
   input  logic                             in_last,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [ACC_NON_FRAC+ACC_FRAC-1:0] out_acc,
   output logic                             out_inf,
   output logic                             out_inf_sign,
   output logic                             out_nan,
   output logic                             out_overflow
);

   localparam int W = acc_width(ACC_NON_FRAC, ACC_FRAC);

   acc_state_t     state_reg, state_next;
   logic           s1_valid_reg, s1_sign_reg, s1_zero_reg, s1_inf_reg, s1_last_reg;
   logic [M+F-1:0] s1_log_reg;
   logic [W-1:0]   acc_reg, acc_next, out_acc_reg;
   kulisch_flags_t flags_reg, flags_next, out_flags_reg;
   logic           s1_advance, beat_ovf, last_advance;

   // A waiting last beat blocks only while an unconsumed result is held.
   assign s1_advance   = s1_valid_reg & ~(s1_last_reg & (state_reg == HOLD) & ~out_ready);
   assign last_advance = s1_advance & s1_last_reg;
   assign in_ready     = ~s1_valid_reg | s1_advance;

   kulisch_log_add #(
      .M(M), .F(F), .LOG_TO_LINEAR_BITS(LOG_TO_LINEAR_BITS), .ACC_FRAC(ACC_FRAC), .W(W)
   ) u_log_add (
      .acc_in(acc_reg), .sign(s1_sign_reg), .zero(s1_zero_reg), .inf(s1_inf_reg),
      .log_in(s1_log_reg), .acc_out(acc_next), .ovf(beat_ovf)
   );

   kulisch_flag_merge #(.OVERFLOW_DETECTION(OVERFLOW_DETECTION)) u_flag_merge (
      .cur(flags_reg), .beat_inf(s1_inf_reg), .beat_sign(s1_sign_reg),
      .beat_ovf(beat_ovf), .merged(flags_next)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid_reg <= 1'b0;
         s1_sign_reg  <= 1'b0;
         s1_zero_reg  <= 1'b0;
         s1_inf_reg   <= 1'b0;
         s1_last_reg  <= 1'b0;
         s1_log_reg   <= '0;
      end else if (in_ready) begin
         s1_valid_reg <= in_valid;
         if (in_valid) begin
            s1_sign_reg <= in_sign;
            s1_zero_reg <= in_zero;
            s1_inf_reg  <= in_inf;
            s1_last_reg <= in_last;
            s1_log_reg  <= in_log;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_reg       <= '0;
         flags_reg     <= '0;
         out_acc_reg   <= '0;
         out_flags_reg <= '0;
      end else if (s1_advance) begin
         if (s1_last_reg) begin
            acc_reg       <= '0;
            flags_reg     <= '0;
            out_acc_reg   <= acc_next;
            out_flags_reg <= flags_next;
         end else begin
            acc_reg   <= acc_next;
            flags_reg <= flags_next;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= ACCUM;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ACCUM: if (last_advance) state_next = HOLD;
         HOLD:  if (!last_advance && out_ready) state_next = ACCUM;
         default: state_next = ACCUM;
      endcase
   end

   always_comb begin
      out_valid    = (state_reg == HOLD);
      out_acc      = out_acc_reg;
      out_inf      = out_flags_reg.inf;
      out_inf_sign = out_flags_reg.inf_sign;
      out_nan      = out_flags_reg.nan;
      out_overflow = out_flags_reg.overflow;
   end

endmodule

// File: tb/tb_log_kulisch_accumulator.sv
// Directed scoreboard bench: the driver queues hand-computed sums for each
// vector, the monitor checks every accepted output against the queue.
module tb_log_kulisch_accumulator;

   localparam int M = 5;
   localparam int F = 10;
   localparam int W = 32;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic           in_valid = 1'b0, in_ready;
   logic           in_sign = 1'b0, in_zero = 1'b0, in_inf = 1'b0, in_last = 1'b0;
   logic [M+F-1:0] in_log = '0;
   logic           out_valid, out_ready = 1'b1;
   logic [W-1:0]   out_acc;
   logic           out_inf, out_inf_sign, out_nan, out_overflow;

   typedef struct {
      logic [W-1:0] acc;
      logic [3:0]   flags;   // {inf, inf_sign, nan, overflow}
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;

   localparam logic [M+F-1:0] LOG_ONE  = 15'h0000;
   localparam logic [M+F-1:0] LOG_TWO  = 15'h0400;
   localparam logic [M+F-1:0] LOG_HALF = 15'h7C00;
   localparam logic [M+F-1:0] LOG_2P14 = 15'h3800;

   always #5 clock = ~clock;

   log_kulisch_accumulator #(
      .M(M), .F(F), .LOG_TO_LINEAR_BITS(8), .ACC_NON_FRAC(16), .ACC_FRAC(16),
      .OVERFLOW_DETECTION(1)
   ) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_zero(in_zero),
      .in_inf(in_inf), .in_log(in_log), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
      .out_inf(out_inf), .out_inf_sign(out_inf_sign), .out_nan(out_nan),
      .out_overflow(out_overflow)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic expect_res(input logic [W-1:0] acc, input logic [3:0] flags);
      exp_t e;
      e.acc = acc;
      e.flags = flags;
      sb_q.push_back(e);
   endtask

   // Presents one beat and returns #1 after the edge that accepted it.
   task automatic send(input logic sgn, input logic zr, input logic inf,
                       input logic [M+F-1:0] lg, input logic lst, input bit no_stall);
      int  waits = 0;
      bit  ok = 0;
      in_valid = 1'b1;
      in_sign = sgn;
      in_zero = zr;
      in_inf = inf;
      in_log = lg;
      in_last = lst;
      while (!ok && waits < 50) begin
         @(negedge clock);
         ok = in_ready;
         @(posedge clock);
         #1;
         if (!ok) waits++;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL accept_timeout actual=no_accept required=accept");
      end
      if (no_stall) check("no_stall_cycles", waits, 0);
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result actual=%h required=none", out_acc);
         end else begin
            mon_e = sb_q.pop_front();
            check("out_acc", out_acc, mon_e.acc);
            check("out_flags", {out_inf, out_inf_sign, out_nan, out_overflow}, mon_e.flags);
            $display("result acc=%h flags=%b expected acc=%h flags=%b",
                     out_acc, {out_inf, out_inf_sign, out_nan, out_overflow},
                     mon_e.acc, mon_e.flags);
         end
      end
   end

   initial begin
      int n;
      repeat (2) @(posedge clock);
      #1;
      check("reset_out_valid", out_valid, 0);
      check("reset_out_acc", out_acc, 0);
      check("reset_out_flags", {out_inf, out_inf_sign, out_nan, out_overflow}, 0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      check("post_reset_in_ready", in_ready, 1);

      // 1.0 + 1.0 + 1.0, with output latency checked directly
      expect_res(32'h0003_0000, 4'b0000);
      send(0, 0, 0, LOG_ONE, 0, 1);
      send(0, 0, 0, LOG_ONE, 0, 1);
      send(0, 0, 0, LOG_ONE, 1, 1);
      check("latency_not_yet", out_valid, 0);
      @(posedge clock);
      #1;
      check("latency_valid", out_valid, 1);

      // 2.0 - 1.0, then a single-beat 0.5 proving the accumulator cleared
      expect_res(32'h0001_0000, 4'b0000);
      send(0, 0, 0, LOG_TWO, 0, 1);
      send(1, 0, 0, LOG_ONE, 1, 1);
      expect_res(32'h0000_8000, 4'b0000);
      send(0, 0, 0, LOG_HALF, 1, 1);

      // +inf, 1.0, -inf -> nan; next vector has clean flags
      expect_res(32'h0001_0000, 4'b0010);
      send(0, 0, 1, LOG_ONE, 0, 1);
      send(0, 0, 0, LOG_ONE, 0, 1);
      send(1, 0, 1, LOG_ONE, 1, 1);
      expect_res(32'h0001_0000, 4'b0000);
      send(0, 0, 0, LOG_ONE, 1, 1);

      // zero beat contributes nothing; back-to-back single-beat vectors
      expect_res(32'h0002_0000, 4'b0000);
      send(0, 1, 0, LOG_TWO, 0, 1);
      send(0, 0, 0, LOG_TWO, 1, 1);
      expect_res(32'h0001_0000, 4'b0000);
      send(0, 0, 0, LOG_ONE, 1, 1);
      expect_res(32'h0000_8000, 4'b0000);
      send(0, 0, 0, LOG_HALF, 1, 1);
      repeat (3) @(posedge clock);
      #1;

      // result held under backpressure while the next vector streams in
      out_ready = 1'b0;
      expect_res(32'h0001_0000, 4'b0000);
      send(0, 0, 0, LOG_ONE, 1, 1);
      expect_res(32'h0005_0000, 4'b0000);
      for (int i = 0; i < 4; i++) send(0, 0, 0, LOG_ONE, 0, 1);
      send(0, 0, 0, LOG_ONE, 1, 1);
      for (int i = 0; i < 3; i++) begin
         check("hold_in_ready_low", in_ready, 0);
         check("hold_out_valid", out_valid, 1);
         check("hold_out_acc_stable", out_acc, 32'h0001_0000);
         @(posedge clock);
         #1;
      end
      out_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;

      // 2^14 three times wraps and sets sticky overflow
      expect_res(32'hC000_0000, 4'b0001);
      send(0, 0, 0, LOG_2P14, 0, 1);
      send(0, 0, 0, LOG_2P14, 0, 1);
      send(0, 0, 0, LOG_2P14, 1, 1);
      repeat (3) @(posedge clock);
      #1;

      // reset mid-vector discards the partial sum
      send(0, 0, 0, LOG_ONE, 0, 1);
      send(0, 0, 0, LOG_ONE, 0, 1);
      reset = 1'b1;
      #1;
      check("mid_reset_out_valid", out_valid, 0);
      @(posedge clock);
      #1;
      check("mid_reset_out_valid_clk", out_valid, 0);
      check("mid_reset_out_acc", out_acc, 0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      expect_res(32'h0001_0000, 4'b0000);
      send(0, 0, 0, LOG_ONE, 1, 1);

      n = 0;
      while (sb_q.size() > 0 && n < 50) begin
         @(posedge clock);
         n++;
      end
      #1;
      check("scoreboard_drained", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
